// File: rtl/frame_sequencer_pkg.sv
// rtl/frame_sequencer_pkg.sv - shared image-processing types for the frame sequencer
package frame_sequencer_pkg;

  // Sequencer life cycle: idle, feeding raster pixels, waiting for the last window, one-cycle done.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int unsigned DEF_IMAGE_HEIGHT = 768;
  localparam int unsigned DEF_IMAGE_WIDTH  = 1024;
  localparam int unsigned DEF_KERNEL_SIZE  = 3;

  // Bits needed to count 0..n-1; never narrower than one bit so degenerate ranges stay legal.
  function automatic int unsigned coord_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Coordinate types for the default image geometry.
  typedef logic [coord_bits(DEF_IMAGE_HEIGHT)-1:0] row_t;
  typedef logic [coord_bits(DEF_IMAGE_WIDTH)-1:0]  col_t;
  typedef logic [coord_bits(DEF_IMAGE_HEIGHT-DEF_KERNEL_SIZE+1)-1:0] win_row_t;
  typedef logic [coord_bits(DEF_IMAGE_WIDTH-DEF_KERNEL_SIZE+1)-1:0]  win_col_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - coordinate-tagged pixel stream interface
interface internal_axi4_stream_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ROW_BITS  = 10,
  parameter int unsigned COL_BITS  = 10
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;
  logic [ROW_BITS-1:0]  row;
  logic [COL_BITS-1:0]  column;

  modport master (output valid, data, row, column, input ready);
  modport slave  (input valid, data, row, column, output ready);
endinterface

// File: rtl/frame_sequencer_raster_counter.sv
// rtl/frame_sequencer_raster_counter.sv - row/column raster position counter
module raster_counter
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned HEIGHT   = 768,
  parameter int unsigned WIDTH    = 1024,
  parameter int unsigned ROW_BITS = 10,
  parameter int unsigned COL_BITS = 10
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                enable_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [COL_BITS-1:0] column_o,
  output logic                last_o
);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(HEIGHT - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(WIDTH - 1);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] column_q, column_d;

  assign last_o   = (row_q == ROW_LAST) && (column_q == COL_LAST);
  assign row_o    = row_q;
  assign column_o = column_q;

  // Advance in raster order; the final position is sticky until cleared.
  always_comb begin
    row_d    = row_q;
    column_d = column_q;
    if (clear_i) begin
      row_d    = '0;
      column_d = '0;
    end else if (enable_i && !last_o) begin
      if (column_q == COL_LAST) begin
        column_d = '0;
        row_d    = row_q + ROW_BITS'(1);
      end else begin
        column_d = column_q + COL_BITS'(1);
      end
    end
  end

  // Position register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      row_q    <= '0;
      column_q <= '0;
    end else begin
      row_q    <= row_d;
      column_q <= column_d;
    end
  end
endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - sequences one raster frame into a sliding-window pipeline
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned ITEM_BITS    = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned IMAGE_HEIGHT = 768,
  parameter int unsigned IMAGE_WIDTH  = 1024,
  localparam int unsigned ROW_BITS     = coord_bits(IMAGE_HEIGHT),
  localparam int unsigned COL_BITS     = coord_bits(IMAGE_WIDTH),
  localparam int unsigned WIN_ROW_BITS = coord_bits(IMAGE_HEIGHT - KERNEL_SIZE + 1),
  localparam int unsigned WIN_COL_BITS = coord_bits(IMAGE_WIDTH - KERNEL_SIZE + 1)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    pixel_valid_i,
  output logic                    pixel_ready_o,
  input  logic [ITEM_BITS-1:0]    pixel_data_i,
  internal_axi4_stream_if.master  feed_master_port,
  input  logic                    window_valid_i,
  input  logic                    window_ready_i,
  input  logic [WIN_ROW_BITS-1:0] window_row_i,
  input  logic [WIN_COL_BITS-1:0] window_column_i,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic [15:0]             frame_count_o
);
  localparam logic [WIN_ROW_BITS-1:0] WIN_ROW_LAST = WIN_ROW_BITS'(IMAGE_HEIGHT - KERNEL_SIZE);
  localparam logic [WIN_COL_BITS-1:0] WIN_COL_LAST = WIN_COL_BITS'(IMAGE_WIDTH - KERNEL_SIZE);

  seq_state_t state_q, state_d;

  logic                 feed_valid_q;
  logic [ITEM_BITS-1:0] feed_data_q;
  logic [ROW_BITS-1:0]  feed_row_q;
  logic [COL_BITS-1:0]  feed_col_q;
  logic [15:0]          frame_count_q;

  logic                feed_ready;
  logic                pixel_accept;
  logic                counter_clear;
  logic [ROW_BITS-1:0] cur_row;
  logic [COL_BITS-1:0] cur_col;
  logic                raster_last;
  logic                final_window;

  assign feed_ready    = feed_master_port.ready;
  assign pixel_ready_o = (state_q == ST_FEED) && (!feed_valid_q || feed_ready);
  assign pixel_accept  = pixel_ready_o && pixel_valid_i;
  assign counter_clear = abort_i || ((state_q == ST_IDLE) && start_i);
  assign final_window  = window_valid_i && window_ready_i &&
                         (window_row_i == WIN_ROW_LAST) && (window_column_i == WIN_COL_LAST);

  assign busy_o        = (state_q != ST_IDLE);
  assign frame_done_o  = (state_q == ST_DONE) && !abort_i;
  assign frame_count_o = frame_count_q;

  assign feed_master_port.valid  = feed_valid_q;
  assign feed_master_port.data   = feed_data_q;
  assign feed_master_port.row    = feed_row_q;
  assign feed_master_port.column = feed_col_q;

  raster_counter #(
    .HEIGHT   (IMAGE_HEIGHT),
    .WIDTH    (IMAGE_WIDTH),
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_raster (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clear_i  (counter_clear),
    .enable_i (pixel_accept),
    .row_o    (cur_row),
    .column_o (cur_col),
    .last_o   (raster_last)
  );

  // Next state; abort overrides every transition, including a start in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FEED;
      ST_FEED:  if (pixel_accept && raster_last) state_d = ST_DRAIN;
      ST_DRAIN: if (final_window) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Feed output register: load on accept, hold while stalled, empty once taken.
  always_ff @(posedge clock_i) begin
    if (reset_i || abort_i) begin
      feed_valid_q <= 1'b0;
    end else if (pixel_accept) begin
      feed_valid_q <= 1'b1;
      feed_data_q  <= pixel_data_i;
      feed_row_q   <= cur_row;
      feed_col_q   <= cur_col;
    end else if (feed_ready) begin
      feed_valid_q <= 1'b0;
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clock_i) begin
    if (reset_i)           frame_count_q <= '0;
    else if (frame_done_o) frame_count_q <= frame_count_q + 16'd1;
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer
module tb_frame_sequencer;
  localparam int H = 4;
  localparam int W = 4;
  localparam int K = 3;
  localparam int NPIX = H * W;

  typedef struct {
    logic [7:0] d;
    logic [1:0] r;
    logic [1:0] c;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, abort_i;
  logic       pixel_valid_i, pixel_ready_o;
  logic [7:0] pixel_data_i;
  logic       window_valid_i, window_ready_i;
  logic [0:0] window_row_i, window_column_i;
  logic       busy_o, frame_done_o;
  logic [15:0] frame_count_o;

  internal_axi4_stream_if #(.DATA_BITS(8), .ROW_BITS(2), .COL_BITS(2)) feed ();

  frame_sequencer #(
    .ITEM_BITS(8), .KERNEL_SIZE(K), .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .pixel_valid_i    (pixel_valid_i),
    .pixel_ready_o    (pixel_ready_o),
    .pixel_data_i     (pixel_data_i),
    .feed_master_port (feed),
    .window_valid_i   (window_valid_i),
    .window_ready_i   (window_ready_i),
    .window_row_i     (window_row_i),
    .window_column_i  (window_column_i),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .frame_count_o    (frame_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  item_t exp_q[$];
  int done_cyc_q[$];
  int done_cnt_q[$];
  int exp_frames = 0;
  int dones_seen = 0;
  int n_acc = 0;
  bit frame_live = 0;
  bit win_pend = 0;
  logic [0:0] win_r, win_c;
  bit stall_armed = 0;
  int stall_left = 0;
  bit hold_last = 0;
  bit rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Downstream sink: stall at pixel 5 on request, optionally hold the last pixel, else ready/random.
  initial begin
    feed.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_armed && feed.valid && feed.data == 8'd5) begin
        stall_left = 3;
        stall_armed = 0;
      end
      if (stall_left > 0) begin
        feed.ready = 1'b0;
        stall_left--;
      end else if (hold_last && feed.valid && feed.row == 2'd3 && feed.column == 2'd3)
        feed.ready = 1'b0;
      else if (rand_ready)
        feed.ready = ($urandom_range(0, 3) != 0);
      else
        feed.ready = 1'b1;
    end
  end

  // Sliding-window model: a pixel at (r,c) with r,c >= K-1 completes window (r-K+1, c-K+1).
  initial begin
    window_valid_i = 0; window_ready_i = 1; window_row_i = 0; window_column_i = 0;
    forever begin
      @(posedge clk); #1;
      if (win_pend) begin
        window_valid_i = 1; window_row_i = win_r; window_column_i = win_c; win_pend = 0;
      end else window_valid_i = 0;
    end
  end

  // Monitor: compares feed transfers, stall behaviour and done pulses against the queues.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (feed.valid && feed.ready) begin
        if (exp_q.size() == 0) fail_now("feed_unexpected_transfer");
        else begin
          it = exp_q.pop_front();
          check("feed_data", feed.data, it.d);
          check("feed_row", feed.row, it.r);
          check("feed_col", feed.column, it.c);
        end
        if (feed.row >= 2'(K - 1) && feed.column >= 2'(K - 1)) begin
          win_pend = 1;
          win_r = 1'(feed.row - 2'(K - 1));
          win_c = 1'(feed.column - 2'(K - 1));
        end
      end else if (feed.valid) begin
        check("stall_pixel_ready", pixel_ready_o, 0);
        if (exp_q.size() > 0) begin
          check("stall_hold_data", feed.data, exp_q[0].d);
          check("stall_hold_row", feed.row, exp_q[0].r);
          check("stall_hold_col", feed.column, exp_q[0].c);
        end
      end
      if (window_valid_i && window_ready_i && window_row_i == 1'(H - K) &&
          window_column_i == 1'(W - K) && frame_live && n_acc == NPIX) begin
        done_cyc_q.push_back(cyc);
        done_cnt_q.push_back(exp_frames);
        exp_frames = (exp_frames + 1) % 65536;
        frame_live = 0;
      end
      if (frame_done_o) begin
        dones_seen++;
        if (done_cyc_q.size() == 0) fail_now("frame_done_unexpected");
        else begin
          check("done_latency", cyc, done_cyc_q.pop_front() + 1);
          check("done_count_before", frame_count_o, done_cnt_q.pop_front());
        end
      end
    end
  end

  task automatic do_start();
    start_i = 1; @(posedge clk); #1; start_i = 0;
    frame_live = 1; n_acc = 0;
  endtask

  task automatic pulse_start_ignored();
    start_i = 1; @(posedge clk); #1; start_i = 0;
  endtask

  task automatic send_pixels(input int first, input int count, input bit rnd, input bit gaps);
    bit acc;
    for (int i = first; i < first + count; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        pixel_valid_i = 0; @(posedge clk); #1;
      end
      pixel_valid_i = 1;
      pixel_data_i = rnd ? 8'($urandom) : 8'(i);
      acc = 0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        if (pixel_ready_o) begin
          item_t it;
          it.d = pixel_data_i; it.r = 2'(i / W); it.c = 2'(i % W);
          exp_q.push_back(it);
          n_acc++;
          acc = 1;
        end
        @(posedge clk); #1;
      end
      if (!acc) fail_now("pixel_accept_timeout");
    end
    pixel_valid_i = 0;
  endtask

  task automatic wait_done(input int target);
    bit got = 0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(posedge clk);
      if (dones_seen >= target) got = 1;
    end
    #1;
    if (!got) fail_now("frame_done_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1; start_i = 0; abort_i = 0; pixel_valid_i = 0; pixel_data_i = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy_o, 0);
    check("rst_pixel_ready", pixel_ready_o, 0);
    check("rst_feed_valid", feed.valid, 0);
    check("rst_frame_count", frame_count_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    rst = 0;
    @(posedge clk); #1;
    check("idle_pixel_ready", pixel_ready_o, 0);

    // Frame 1: pixels 0..15 back to back.
    do_start();
    check("feed_busy", busy_o, 1);
    check("feed_pixel_ready", pixel_ready_o, 1);
    send_pixels(0, NPIX, 0, 0);
    wait_done(1);
    check("frame1_count", frame_count_o, 1);
    check("frame1_busy", busy_o, 0);

    // Frame 2: three-cycle stall at pixel 5; start ignored in FEED and DRAIN.
    stall_armed = 1;
    do_start();
    send_pixels(0, 4, 0, 0);
    pulse_start_ignored();
    check("start_in_feed_busy", busy_o, 1);
    send_pixels(4, NPIX - 4, 0, 0);
    pulse_start_ignored();
    check("start_in_drain_busy", busy_o, 1);
    wait_done(2);
    check("frame2_count", frame_count_o, 2);
    check("frame2_queue_empty", exp_q.size(), 0);

    // Abort at pixel 9, then a full restart from (0,0).
    do_start();
    send_pixels(0, 9, 1, 0);
    abort_i = 1; @(posedge clk); #1; abort_i = 0;
    exp_q.delete(); frame_live = 0; win_pend = 0;
    check("abort_busy", busy_o, 0);
    check("abort_feed_valid", feed.valid, 0);
    check("abort_count", frame_count_o, 2);
    check("abort_pixel_ready", pixel_ready_o, 0);
    do_start();
    send_pixels(0, NPIX, 1, 0);
    wait_done(3);
    check("restart_count", frame_count_o, 3);

    // Start together with abort in IDLE stays IDLE.
    start_i = 1; abort_i = 1; @(posedge clk); #1; start_i = 0; abort_i = 0;
    check("start_abort_busy", busy_o, 0);
    check("start_abort_pixel_ready", pixel_ready_o, 0);

    // Reset while draining with the last pixel held downstream.
    base = dones_seen;
    hold_last = 1;
    do_start();
    send_pixels(0, NPIX, 1, 0);
    repeat (3) @(posedge clk); #1;
    check("drain_busy", busy_o, 1);
    rst = 1; @(posedge clk); #1;
    check("drain_rst_busy", busy_o, 0);
    check("drain_rst_pixel_ready", pixel_ready_o, 0);
    check("drain_rst_feed_valid", feed.valid, 0);
    check("drain_rst_count", frame_count_o, 0);
    check("drain_rst_done", frame_done_o, 0);
    rst = 0;
    exp_q.delete(); frame_live = 0; win_pend = 0; exp_frames = 0; hold_last = 0;
    repeat (10) @(posedge clk); #1;
    check("drain_rst_no_done", dones_seen, base);

    // Two frames with random valid gaps and random downstream ready.
    rand_ready = 1;
    base = dones_seen;
    do_start();
    send_pixels(0, NPIX, 1, 1);
    wait_done(base + 1);
    do_start();
    send_pixels(0, NPIX, 1, 1);
    wait_done(base + 2);
    rand_ready = 0;
    repeat (5) @(posedge clk); #1;
    check("random_count", frame_count_o, 2);
    check("random_done_pulses", dones_seen - base, 2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
